// File: rtl/uart_inst_loader_if.sv
// Byte-in / instruction-out bundle between the UART receiver, the loader and seq.
// The master side drives the i_* signals; the loader (slave) drives the o_* signals.
interface uart_inst_loader_if #(
    parameter int INST_WIDTH = 8,
    parameter int CNT_W      = 5
);
    logic [7:0]            i_rx_data;
    logic                  i_rx_valid;
    logic                  i_tx_busy;
    logic                  i_run;
    logic                  i_flush;
    logic [INST_WIDTH-1:0] o_inst;
    logic                  o_inst_valid;
    logic [CNT_W-1:0]      o_count;
    logic                  o_overflow;
    logic [7:0]            o_issued;

    modport master (
        output i_rx_data, i_rx_valid, i_tx_busy, i_run, i_flush,
        input  o_inst, o_inst_valid, o_count, o_overflow, o_issued
    );

    modport slave (
        input  i_rx_data, i_rx_valid, i_tx_busy, i_run, i_flush,
        output o_inst, o_inst_valid, o_count, o_overflow, o_issued
    );
endinterface

// File: rtl/uart_inst_loader.sv
// Buffers UART bytes in a FIFO and issues them to seq as paced instructions.
// Issue waits for run, a non-empty FIFO and an idle transmitter, then a fixed gap.
module uart_inst_loader #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 16,
    parameter int INST_WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    uart_inst_loader_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP
    } state_t;

    state_t                r_state;
    logic [INST_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [GW-1:0]         r_gap;
    logic [INST_WIDTH-1:0] r_inst;
    logic                  r_inst_valid;
    logic                  r_overflow;
    logic [7:0]            r_issued;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full = (r_count == CW'(DEPTH));
    // Flush wins over both ends of the FIFO in the same cycle.
    assign w_pop  = (r_state == S_IDLE) && bus.i_run && (r_count != '0)
                    && !bus.i_tx_busy && !bus.i_flush;
    assign w_push = bus.i_rx_valid && !bus.i_flush && (!w_full || w_pop);
    assign w_drop = bus.i_rx_valid && !bus.i_flush && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.i_rx_data[INST_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_state      <= S_IDLE;
            r_gap        <= '0;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_issued     <= '0;
        end else begin
            if (bus.i_flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_push && !w_pop) r_count <= r_count + 1'b1;
                if (!w_push && w_pop) r_count <= r_count - 1'b1;
                if (w_drop) r_overflow <= 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_inst       <= r_mem[r_rd_ptr];
                        r_inst_valid <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_inst_valid <= 1'b0;
                    r_issued     <= r_issued + 1'b1;
                    r_gap        <= GW'(GAP_CYCLES);
                    r_state      <= S_GAP;
                end
                S_GAP: begin
                    r_gap <= r_gap - 1'b1;
                    if (r_gap == GW'(1)) r_state <= S_IDLE;
                end
                default: begin
                    r_inst_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_inst       = r_inst;
    assign bus.o_inst_valid = r_inst_valid;
    assign bus.o_count      = r_count;
    assign bus.o_overflow   = r_overflow;
    assign bus.o_issued     = r_issued;
endmodule

// File: tb/tb_uart_inst_loader.sv
// Randomised scoreboard bench for uart_inst_loader.
// A queue-level model predicts pulses; a negedge monitor pops and compares them.
module tb_uart_inst_loader;
    localparam int DEPTH = 16;
    localparam int GAP   = 16;
    localparam int IW    = 8;
    localparam int CW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_inst_loader_if #(.INST_WIDTH(IW), .CNT_W(CW)) bus ();

    uart_inst_loader #(
        .DEPTH(DEPTH),
        .GAP_CYCLES(GAP),
        .INST_WIDTH(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [7:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   last_pulse = -1;

    // Reference model: byte queue, sticky overflow, issue count, time the engine is free.
    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    int         m_issued = 0;
    int         m_free = 0;
    int         m_inc_q[$];

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                     name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse at cycle %0d: got none, expected 0x%02h at cycle %0d",
                     cyc, exp_q[0].v, exp_q[0].t);
            void'(exp_q.pop_front());
        end
        if (bus.o_inst_valid === 1'b1) begin
            pulses++;
            last_pulse = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d: got 0x%02h, expected no pulse",
                         cyc, bus.o_inst);
            end else begin
                e = exp_q.pop_front();
                check("pulse_time", cyc, e.t);
                check("pulse_data", int'(bus.o_inst), int'(e.v));
            end
        end
    end

    task automatic step(bit v, logic [7:0] d, bit busy, bit run, bit fl, bit r);
        bit   pop;
        exp_t e;
        while (m_inc_q.size() > 0 && m_inc_q[0] <= cyc) begin
            void'(m_inc_q.pop_front());
            m_issued = (m_issued + 1) % 256;
        end
        check("count", int'(bus.o_count), m_q.size());
        check("overflow", int'(bus.o_overflow), int'(m_ovf));
        check("issued", int'(bus.o_issued), m_issued);

        rst            = r;
        bus.i_rx_valid = v;
        bus.i_rx_data  = d;
        bus.i_tx_busy  = busy;
        bus.i_run      = run;
        bus.i_flush    = fl;

        if (r) begin
            m_q.delete();
            m_inc_q.delete();
            m_ovf    = 1'b0;
            m_issued = 0;
            m_free   = cyc + 1;
        end else begin
            pop = (cyc >= m_free) && run && (m_q.size() > 0) && !busy && !fl;
            if (pop) begin
                e.t = cyc + 1;
                e.v = m_q.pop_front();
                exp_q.push_back(e);
                m_free = cyc + 2 + GAP;
                m_inc_q.push_back(cyc + 2);
            end
            if (fl) begin
                m_q.delete();
                m_ovf = 1'b0;
            end else if (v) begin
                if (m_q.size() < DEPTH) m_q.push_back(d);
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n, bit run, bit busy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, busy, run, 1'b0, 1'b0);
    endtask

    initial begin
        int b_last;
        int p0;
        int guard;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        bus.i_tx_busy  = 1'b0;
        bus.i_run      = 1'b0;
        bus.i_flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_free = cyc;

        // single byte: pulse two cycles after the strobe
        step(1'b1, 8'h2A, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(25, 1'b1, 1'b0);
        check("single_issued", int'(bus.o_issued), 1);

        // burst 0x01..0x05 paced GAP+2 apart
        for (int i = 1; i <= 5; i++)
            step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        idle(110, 1'b1, 1'b0);

        // overflow with run low, then drain, then flush clears the flag
        for (int i = 0; i < 17; i++)
            step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0, 1'b0);
        check("ovf_count", int'(bus.o_count), 16);
        check("ovf_flag", int'(bus.o_overflow), 1);
        idle(16 * (GAP + 2) + 10, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b0);
        check("flush_ovf", int'(bus.o_overflow), 0);

        // busy hold: pulse two cycles after the last busy-high cycle
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b1, 1'b0, 1'b0);
        idle(97, 1'b1, 1'b1);
        b_last = cyc - 1;
        p0 = pulses;
        idle(4, 1'b1, 1'b0);
        check("busy_release", last_pulse, b_last + 2);
        check("busy_one_pulse", pulses - p0, 1);
        idle(3 * (GAP + 2), 1'b1, 1'b0);

        // full FIFO with a write in the same cycle as the pop
        for (int i = 0; i < 16; i++)
            step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        check("full_pop_count", int'(bus.o_count), 16);
        check("full_pop_ovf", int'(bus.o_overflow), 0);
        idle(16 * (GAP + 2) + 10, 1'b1, 1'b0);

        // random traffic until the issue counter has wrapped
        guard = 0;
        while (pulses < 300 && guard < 20000) begin
            step($urandom_range(0, 3) == 0, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) != 0,
                 $urandom_range(0, 499) == 0, 1'b0);
            guard++;
        end
        check("wrap_reached", int'(pulses >= 256), 1);
        idle(20 * (GAP + 2), 1'b1, 1'b0);

        // reset with five bytes queued and the engine in its gap
        for (int i = 0; i < 6; i++)
            step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_count", int'(bus.o_count), 5);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        check("rst_count", int'(bus.o_count), 0);
        check("rst_valid", int'(bus.o_inst_valid), 0);
        p0 = pulses;
        idle(60, 1'b1, 1'b0);
        check("rst_no_pulse", pulses - p0, 0);
        step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(25, 1'b1, 1'b0);
        check("post_rst_issued", int'(bus.o_issued), 1);
        check("pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
